// File: rtl/issue_ctrl.sv
// Issue controller: GPR write scoreboard, in-flight limit, control-transfer
// serialisation and EBREAK drain/halt sequencing between decode and execute.
module issue_ctrl #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [4:0]       i_rd,
  input  logic             i_rs1_used,
  input  logic             i_rs2_used,
  input  logic             i_wb_we,
  input  logic             i_ctrl,
  input  logic             i_ebreak,
  input  logic             i_retire,
  input  logic             i_retire_we,
  input  logic [4:0]       i_retire_rd,
  input  logic             i_br_resolve,
  input  logic             i_br_taken,
  output logic             o_issue,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_in_flight,
  output logic [NREGS-1:0] o_pending,
  output logic             o_err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_BR_WAIT = 2'd1,
    S_DRAIN   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [NREGS-1:0] r_pending;
  logic [CNT_W-1:0] r_in_flight;
  logic             r_flush;
  logic             r_halted;
  logic             r_err;

  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_eff;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_pending_nxt;
  logic             w_hazard;
  logic             w_cap_ok;
  logic             w_issue;
  logic             w_inc;
  logic             w_underflow;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_bad_retire;
  logic             w_bad_resolve;
  logic             w_flush_nxt;
  logic             w_halted_nxt;
  logic             w_err_nxt;

  // Scoreboard bypass, hazard detection, issue decision and counter update
  always_comb begin
    w_clr         = '0;
    w_set         = '0;
    w_eff         = '0;
    w_hazard      = 1'b0;
    w_cap_ok      = 1'b0;
    w_issue       = 1'b0;
    w_inc         = 1'b0;
    w_underflow   = 1'b0;
    w_cnt_nxt     = r_in_flight;
    w_bad_retire  = 1'b0;
    w_bad_resolve = 1'b0;
    w_pending_nxt = r_pending;

    if (i_retire && i_retire_we && (i_retire_rd != 5'd0)) begin
      w_clr = NREGS'(1) << i_retire_rd;
    end
    w_eff = r_pending & ~w_clr;

    w_hazard = (i_rs1_used && (i_rs1 != 5'd0) && w_eff[i_rs1]) ||
               (i_rs2_used && (i_rs2 != 5'd0) && w_eff[i_rs2]) ||
               (i_wb_we    && (i_rd  != 5'd0) && w_eff[i_rd]);

    w_cap_ok = (r_in_flight < MAX_C) || i_retire;

    // EBREAK bypasses hazard and capacity checks; it only needs RUN
    w_issue = i_rst_n && i_valid && (r_state == S_RUN) &&
              (i_ebreak || (!w_hazard && w_cap_ok));

    if (w_issue && i_wb_we && (i_rd != 5'd0) && !i_ebreak) begin
      w_set = NREGS'(1) << i_rd;
    end
    w_pending_nxt = w_eff | w_set;

    w_inc       = w_issue && !i_ebreak;
    w_underflow = i_retire && (r_in_flight == '0);
    if (w_underflow) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_in_flight + CNT_W'(w_inc) - CNT_W'(i_retire);
    end

    w_bad_retire  = i_retire && i_retire_we && (i_retire_rd != 5'd0) &&
                    !r_pending[i_retire_rd];
    w_bad_resolve = i_br_resolve && (r_state != S_BR_WAIT);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_issue && i_ebreak) begin
          w_state_nxt = S_DRAIN;
        end else if (w_issue && i_ctrl) begin
          w_state_nxt = S_BR_WAIT;
        end
      end
      S_BR_WAIT: begin
        if (i_br_resolve) begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_cnt_nxt == '0) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  // Output logic: combinational handshake plus next values of registered outputs
  always_comb begin
    o_issue      = w_issue;
    o_stall      = i_valid && !w_issue;
    w_flush_nxt  = (r_state == S_BR_WAIT) && i_br_resolve && i_br_taken;
    w_halted_nxt = r_halted || (w_state_nxt == S_HALT);
    w_err_nxt    = r_err || w_bad_resolve || w_bad_retire || w_underflow;
  end

  // Registered outputs and scoreboard
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending   <= '0;
      r_in_flight <= '0;
      r_flush     <= 1'b0;
      r_halted    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_in_flight <= w_cnt_nxt;
      r_flush     <= w_flush_nxt;
      r_halted    <= w_halted_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_flush     = r_flush;
  assign o_halted    = r_halted;
  assign o_in_flight = r_in_flight;
  assign o_pending   = r_pending;
  assign o_err       = r_err;

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue controller between the Decoder and the execute stage of the pipelined core.
- Keeps a scoreboard of in-flight GPR writes and stalls decode on RAW/WAW hazards or in-flight overflow.
- Serialises control transfers: one unresolved branch/jump at a time, with a flush pulse on taken.
- Sequences EBREAK: drain all in-flight instructions, then halt until reset.

Parameters:
- NREGS, 32, GPR count; scoreboard width; x0 never tracked.
- MAX_INFLIGHT, 4, max issued-but-not-retired instructions.
- CNT_W, 3, in-flight counter width; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- _clk  input  1  core clock; all state updates on rising edge.
- _rst_n  input  1  reset, asynchronous assert, active-low.
- _valid  input  1  decode stage holds a valid instruction.
- _rs1  input  5  decoded rs1.
- _rs2  input  5  decoded rs2.
- _rd  input  5  decoded rd.
- _rs1_used  input  1  instruction reads rs1 (0 for U/J).
- _rs2_used  input  1  instruction reads rs2 (R/S/B only).
- _wb_we  input  1  instruction writes rd (decoder sig_wb_we_).
- _ctrl  input  1  branch/jump (sig_fetch_bcond_ | sig_fetch_advance_by_imm_).
- _ebreak  input  1  decoded EBREAK.
- _retire  input  1  one issued instruction completes this cycle.
- _retire_we  input  1  retiring instruction wrote a GPR.
- _retire_rd  input  5  destination of the retiring instruction.
- _br_resolve  input  1  outstanding control transfer resolved this cycle.
- _br_taken  input  1  resolved transfer redirected PC; qualified by _br_resolve.
- issue_  output  1  instruction accepted this cycle (combinational).
- stall_  output  1  _valid & ~issue_ (combinational); holds fetch/decode.
- flush_  output  1  registered one-cycle pulse; kill younger fetched instructions.
- halted_  output  1  registered; core halted after EBREAK.
- in_flight_  output  CNT_W  registered in-flight count.
- pending_  output  NREGS  registered scoreboard; bit i = write to xi outstanding.
- err_  output  1  registered, sticky protocol-violation flag.

Behaviour:
- Reset (_rst_n low, async): state RUN, pending_=0, in_flight_=0, flush_=0, halted_=0, err_=0; issue_ forced 0 while _rst_n low.
- States: RUN, BR_WAIT, DRAIN, HALT. Encoding is free.
- Retire bypass (same cycle):
  - clr = _retire & _retire_we & (_retire_rd != 0) ? onehot(_retire_rd) : 0.
  - eff = pending_ & ~clr.
- Hazard = (_rs1_used & _rs1 != 0 & eff[_rs1]) | (_rs2_used & _rs2 != 0 & eff[_rs2]) | (_wb_we & _rd != 0 & eff[_rd]).
- Issue:
  - issue_ = _valid & state==RUN & ~hazard & (in_flight_ < MAX_INFLIGHT | _retire).
  - An EBREAK issue ignores hazard and capacity; it needs only state==RUN.
- Scoreboard update:
  - pending_ <= eff | set.
  - set = onehot(_rd) when issue_ & _wb_we & _rd != 0 & ~_ebreak; otherwise set = 0.
  - If the same rd is cleared and set in one cycle, set wins.
- Counter:
  - in_flight_ <= in_flight_ + (issue_ & ~_ebreak) - _retire.
  - _retire with in_flight_==0: counter holds at 0 and err_ sets.
- Transitions:
  - RUN -> BR_WAIT: issue_ & _ctrl.
  - RUN -> DRAIN: issue_ & _ebreak. EBREAK is not counted in flight.
  - BR_WAIT -> RUN: on _br_resolve. flush_ <= _br_taken for exactly the next cycle.
  - DRAIN -> HALT: first cycle where in_flight_==0 after the update. halted_ <= 1 on entry.
  - HALT: absorbing; only reset leaves it.
- Retire/writeback continue in every state, including BR_WAIT, DRAIN and HALT.
- err_ sets on any of:
  - _br_resolve outside BR_WAIT;
  - retire-write to an rd whose pending_ bit is 0;
  - retire underflow.
- err_ clears only on reset.
- Latency:
  - Hazard-free issue is same cycle as _valid.
  - A dependent instruction issues in the cycle its producer retires (bypass); no extra bubble.

Test Plan:
- Reset mid-operation: pending_=0x0000_0004, state BR_WAIT; pulse _rst_n low -> all outputs 0, state RUN, next _valid issues immediately.
- RAW hazard:
  - Issue add x5 (wb_we); next cycle addi x6,x5 -> stall_=1, pending_[5]=1.
  - _retire_we rd=5 -> issue_=1 in that same cycle; pending_ = bit6 only afterwards.
- Reads of x0: 4× addi x0,x0 with wb_we -> no pending bits set; rs=0 never stalls.
- Capacity:
  - 4 independent writes to x1..x4 -> in_flight_=4; 5th stalls.
  - With _retire in the same cycle the 5th issues and in_flight_ stays 4.
- Branch:
  - Issue beq -> BR_WAIT; following _valid stalls.
  - _br_resolve & _br_taken -> flush_=1 exactly one cycle, then issue resumes.
  - Not-taken -> flush_ stays 0.
  - _br_resolve while in RUN -> err_=1 and stays set.
- EBREAK drain:
  - 2 in flight, issue ebreak -> DRAIN, stall_=1.
  - After 2 retires, halted_=1 the following cycle and stays high.
  - A retire-write to a non-pending rd -> err_=1.
